// File: rtl/line_ctrl_pkg.sv
// Shared definitions for the line-following wheel controller.
//   state_e   : controller state encoding (value is visible on the state port)
//   sat_sym   : symmetric saturation to a signed width (never the most negative code)
//   clamp_sym : symmetric clamp to +/- a limit
package line_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRACK   = 2'd1,
      ST_SEARCH  = 2'd2,
      ST_STOPPED = 2'd3
   } state_e;

   // Saturate v into [-(2^(w-1)-1), +(2^(w-1)-1)].
   function automatic logic signed [31:0] sat_sym(input logic signed [31:0] v, input int w);
      logic signed [31:0] lim;
      lim = $signed((32'd1 << (w - 1)) - 32'd1);
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      else
         return v;
   endfunction

   // Clamp v into [-lim, +lim].
   function automatic logic signed [31:0] clamp_sym(input logic signed [31:0] v, input int lim);
      logic signed [31:0] l;
      l = lim;
      if (v > l)
         return l;
      else if (v < -l)
         return -l;
      else
         return v;
   endfunction

endpackage

// File: rtl/slew_limiter.sv
// Per-wheel slew-rate limiter. The registered output moves towards the target
// by at most RAMP_STEP per enabled clock; clear forces it to zero immediately.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset (output -> 0)
//   clr_i     in   force output to 0 at the next edge
//   step_i    in   take one slew step towards target_i
//   target_i  in   signed target value (already saturated by the caller)
//   out_o     out  signed registered output
module slew_limiter
   import line_ctrl_pkg::*;
#(
   parameter int WHEEL_W   = 8,
   parameter int RAMP_STEP = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clr_i,
   input  logic                      step_i,
   input  logic signed [WHEEL_W-1:0] target_i,
   output logic signed [WHEEL_W-1:0] out_o
);

   logic signed [WHEEL_W-1:0] out_q, out_d;

   // The step never overshoots the target and the target is in range, so the
   // sum cannot wrap.
   always_comb begin
      out_d = out_q;
      if (clr_i)
         out_d = '0;
      else if (step_i)
         out_d = out_q + WHEEL_W'(clamp_sym(32'(target_i) - 32'(out_q), RAMP_STEP));
   end

   always_ff @(posedge clk) begin
      if (reset)
         out_q <= '0;
      else
         out_q <= out_d;
   end

   assign out_o = out_q;

endmodule

// File: rtl/line_steer_controller.sv
// Line-following wheel controller: weighted-position proportional steering
// from an N-wide sensor bar, per-wheel slew limiting, and a lost-line
// search / stop state machine.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   enable       in   run; low forces IDLE and zero wheels
//   sensors      in   N_SENSORS bits, 1 = line under sensor i (bit 0 leftmost)
//   speed        in   unsigned base forward speed
//   wheel_left   out  signed left wheel command (registered)
//   wheel_right  out  signed right wheel command (registered)
//   state        out  0 IDLE, 1 TRACK, 2 SEARCH, 3 STOPPED
//   line_lost    out  high in SEARCH and STOPPED
module line_steer_controller
   import line_ctrl_pkg::*;
#(
   parameter int N_SENSORS    = 4,
   parameter int SPEED_W      = 6,
   parameter int WHEEL_W      = 8,
   parameter int K_P          = 4,
   parameter int RAMP_STEP    = 4,
   parameter int SEARCH_SPEED = 16,
   parameter int LOST_TIMEOUT = 1000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [N_SENSORS-1:0]      sensors,
   input  logic [SPEED_W-1:0]        speed,
   output logic signed [WHEEL_W-1:0] wheel_left,
   output logic signed [WHEEL_W-1:0] wheel_right,
   output logic [1:0]                state,
   output logic                      line_lost
);

   localparam int INT_W   = WHEEL_W + 6;
   localparam int TIMER_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;
   localparam logic signed [WHEEL_W-1:0] SRCH = WHEEL_W'(SEARCH_SPEED);

   state_e                   state_q, state_d;
   logic [N_SENSORS-1:0]     sensors_q;
   logic                     last_dir_q, last_dir_d;   // 1 = right (+1), 0 = left (-1)
   logic [TIMER_W-1:0]       timer_q, timer_d;

   logic signed [INT_W-1:0]   err, corr, raw_l, raw_r;
   logic signed [WHEEL_W-1:0] trk_l, trk_r, tgt_l, tgt_r;
   logic                      clr, step;

   // Weighted position error and saturated tracking targets.
   always_comb begin
      err = '0;
      for (int i = 0; i < N_SENSORS; i++) begin
         if (sensors_q[i])
            err = err + $signed(INT_W'(2 * i - (N_SENSORS - 1)));
      end
      corr  = err * $signed(INT_W'(K_P));
      raw_l = $signed(INT_W'(speed)) + corr;
      raw_r = $signed(INT_W'(speed)) - corr;
      trk_l = WHEEL_W'(sat_sym(32'(raw_l), WHEEL_W));
      trk_r = WHEEL_W'(sat_sym(32'(raw_r), WHEEL_W));
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      last_dir_d = last_dir_q;
      clr        = 1'b0;
      step       = 1'b0;
      tgt_l      = trk_l;
      tgt_r      = trk_r;
      if (!enable) begin
         state_d = ST_IDLE;
         timer_d = '0;
         clr     = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_TRACK;
               clr     = 1'b1;
            end
            ST_TRACK: begin
               // On the edge the line disappears the wheels hold their value.
               if (sensors_q == '0) begin
                  state_d = ST_SEARCH;
                  timer_d = '0;
               end else begin
                  step = 1'b1;
                  if (err > 0)
                     last_dir_d = 1'b1;
                  else if (err < 0)
                     last_dir_d = 1'b0;
               end
            end
            ST_SEARCH: begin
               // Spin on the spot towards the side the line was last seen.
               step  = 1'b1;
               tgt_l = last_dir_q ? SRCH : -SRCH;
               tgt_r = last_dir_q ? -SRCH : SRCH;
               if (sensors_q != '0)
                  state_d = ST_TRACK;
               else if (timer_q == TIMER_W'(LOST_TIMEOUT - 1))
                  state_d = ST_STOPPED;
               else
                  timer_d = timer_q + 1'b1;
            end
            ST_STOPPED: begin
               clr = 1'b1;
               if (sensors_q != '0)
                  state_d = ST_TRACK;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sensors_q  <= '0;
         last_dir_q <= 1'b1;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         sensors_q  <= sensors;
         last_dir_q <= last_dir_d;
         timer_q    <= timer_d;
      end
   end

   slew_limiter #(.WHEEL_W(WHEEL_W), .RAMP_STEP(RAMP_STEP)) u_slew_l (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (clr),
      .step_i   (step),
      .target_i (tgt_l),
      .out_o    (wheel_left)
   );

   slew_limiter #(.WHEEL_W(WHEEL_W), .RAMP_STEP(RAMP_STEP)) u_slew_r (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (clr),
      .step_i   (step),
      .target_i (tgt_r),
      .out_o    (wheel_right)
   );

   assign state     = state_q;
   assign line_lost = (state_q == ST_SEARCH) || (state_q == ST_STOPPED);

endmodule

// File: tb/tb_line_steer_controller.sv
module tb_line_steer_controller;

   logic              clk = 1'b0;
   logic              reset, enable;
   logic [3:0]        sensors;
   logic [5:0]        speed;
   logic signed [7:0] wl0, wr0, wl1, wr1;
   logic [1:0]        st0, st1;
   logic              ll0, ll1;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   line_steer_controller dut0 (
      .clk(clk), .reset(reset), .enable(enable), .sensors(sensors), .speed(speed),
      .wheel_left(wl0), .wheel_right(wr0), .state(st0), .line_lost(ll0)
   );

   line_steer_controller #(.K_P(32)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .sensors(sensors), .speed(speed),
      .wheel_left(wl1), .wheel_right(wr1), .state(st1), .line_lost(ll1)
   );

   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural reference (integer arithmetic) ----------------
   int kp_tab[2] = '{4, 32};
   int m_st[2], m_wl[2], m_wr[2], m_sq[2], m_tm[2], m_dir[2];

   function automatic int sat127(int v);
      if (v > 127) return 127;
      if (v < -127) return -127;
      return v;
   endfunction

   function automatic int ramp(int cur, int tgt);
      int d;
      d = tgt - cur;
      if (d > 4) d = 4;
      if (d < -4) d = -4;
      return cur + d;
   endfunction

   task automatic model_step(int k);
      int err;
      err = 0;
      for (int i = 0; i < 4; i++)
         if (((m_sq[k] >> i) & 1) != 0) err += 2 * i - 3;
      if (reset) begin
         m_st[k] = 0; m_wl[k] = 0; m_wr[k] = 0; m_sq[k] = 0; m_tm[k] = 0; m_dir[k] = 1;
         return;
      end
      if (!enable) begin
         m_st[k] = 0; m_wl[k] = 0; m_wr[k] = 0; m_tm[k] = 0;
      end else if (m_st[k] == 0) begin
         m_st[k] = 1; m_wl[k] = 0; m_wr[k] = 0;
      end else if (m_st[k] == 1) begin
         if (m_sq[k] == 0) begin
            m_st[k] = 2; m_tm[k] = 0;
         end else begin
            m_wl[k] = ramp(m_wl[k], sat127(int'(speed) + err * kp_tab[k]));
            m_wr[k] = ramp(m_wr[k], sat127(int'(speed) - err * kp_tab[k]));
            if (err > 0) m_dir[k] = 1;
            if (err < 0) m_dir[k] = -1;
         end
      end else if (m_st[k] == 2) begin
         m_wl[k] = ramp(m_wl[k], 16 * m_dir[k]);
         m_wr[k] = ramp(m_wr[k], -16 * m_dir[k]);
         if (m_sq[k] != 0) m_st[k] = 1;
         else if (m_tm[k] == 999) m_st[k] = 3;
         else m_tm[k]++;
      end else begin
         m_wl[k] = 0; m_wr[k] = 0;
         if (m_sq[k] != 0) m_st[k] = 1;
      end
      m_sq[k] = int'(sensors);
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m0_left", int'(wl0), m_wl[0]);
         chk("m0_right", int'(wr0), m_wr[0]);
         chk("m0_state", int'(st0), m_st[0]);
         chk("m0_lost", int'(ll0), int'(m_st[0] >= 2));
         chk("m1_left", int'(wl1), m_wl[1]);
         chk("m1_right", int'(wr1), m_wr[1]);
         chk("m1_state", int'(st1), m_st[1]);
         chk("m1_lost", int'(ll1), int'(m_st[1] >= 2));
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [3:0] sens;
      int         spd;
      bit         en;
      int         ncyc;
      int         el;
      int         er;
      int         est;
   } vec_t;

   vec_t vt[8];

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      vt[0] = '{4'b1000, 32, 1'b1, 20, 44, 20, 1};
      vt[1] = '{4'b0001, 32, 1'b1, 20, 20, 44, 1};
      vt[2] = '{4'b1111, 32, 1'b1, 20, 32, 32, 1};
      vt[3] = '{4'b0110, 50, 1'b1, 20, 50, 50, 1};
      vt[4] = '{4'b1000, 32, 1'b1, 20, 44, 20, 1};
      vt[5] = '{4'b1000, 32, 1'b0, 1, 0, 0, 0};
      vt[6] = '{4'b1000, 32, 1'b1, 1, 0, 0, 1};
      vt[7] = '{4'b1000, 32, 1'b1, 20, 44, 20, 1};

      reset = 1'b1; enable = 1'b1; sensors = 4'b1111; speed = 6'd32;
      cyc(3);
      cmp_en = 1'b1;
      cyc(1);
      chk("rst_left", int'(wl0), 0);
      chk("rst_right", int'(wr0), 0);
      chk("rst_state", int'(st0), 0);
      chk("rst_lost", int'(ll0), 0);

      // Ramp up from rest in 4-unit steps.
      reset = 1'b0; sensors = 4'b0110;
      cyc(1);
      chk("start_state", int'(st0), 1);
      chk("start_left", int'(wl0), 0);
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         chk("ramp_left", int'(wl0), 4 * k);
         chk("ramp_right", int'(wr0), 4 * k);
      end

      for (int v = 0; v < 8; v++) begin
         sensors = vt[v].sens; speed = 6'(vt[v].spd); enable = vt[v].en;
         cyc(vt[v].ncyc);
         chk("vec_left", int'(wl0), vt[v].el);
         chk("vec_right", int'(wr0), vt[v].er);
         chk("vec_state", int'(st0), vt[v].est);
      end

      // Saturation with the high-gain instance.
      speed = 6'd63; sensors = 4'b1100;
      cyc(80);
      chk("sat_left", int'(wl1), 127);
      chk("sat_right", int'(wr1), -65);
      chk("kp4_left", int'(wl0), 79);
      chk("kp4_right", int'(wr0), 47);

      // Lost line: search, timeout to stop, then recovery.
      speed = 6'd32; sensors = 4'b1000;
      cyc(20);
      chk("pre_left", int'(wl0), 44);
      sensors = 4'b0000;
      cyc(2);
      chk("search_state", int'(st0), 2);
      chk("search_lost", int'(ll0), 1);
      cyc(999);
      chk("search_hold", int'(st0), 2);
      chk("search_left", int'(wl0), 16);
      chk("search_right", int'(wr0), -16);
      cyc(1);
      chk("stop_state", int'(st0), 3);
      chk("stop_left_hold", int'(wl0), 16);
      cyc(1);
      chk("stop_left", int'(wl0), 0);
      chk("stop_right", int'(wr0), 0);
      sensors = 4'b0010;
      cyc(2);
      chk("recover_state", int'(st0), 1);
      chk("recover_left0", int'(wl0), 0);
      cyc(1);
      chk("recover_left", int'(wl0), 4);
      chk("recover_right", int'(wr0), 4);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 2500; n++) begin
         reset  = ($urandom_range(0, 149) == 0);
         enable = ($urandom_range(0, 29) != 0);
         if ($urandom_range(0, 7) == 0)
            sensors = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 15) == 0)
            speed = 6'($urandom_range(0, 63));
         cyc(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
